// File: rtl/phase_seq_pkg.sv
// Shared types and limits for the N-phase sequencer and its timer.
package phase_seq_pkg;

  localparam int MAX_NPHASES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } phase_state_t;

endpackage

// File: rtl/phase_timer.sv
// Shared dwell/gap down-counter; expire is combinational on count==0.
// Latency: load takes effect on the next edge. No backpressure.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so an idle timer stays expired without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);
  assign count  = cnt_q;

endmodule

// File: rtl/phase_sequencer.sv
// N-phase non-overlapping one-hot phase-enable generator with dwell, gap and one-shot rounds.
// Latency: phase 0 is driven the edge after enable is seen in IDLE. No backpressure; all outputs registered.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NPHASES = 4,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = $clog2(NPHASES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               oneshot,
  input  logic [CNT_W-1:0]   dwell,
  input  logic [CNT_W-1:0]   gap,
  output logic [NPHASES-1:0] phase_en,
  output logic [IDX_W-1:0]   phase_idx,
  output logic               busy,
  output logic               cycle_done
);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NPHASES - 1);
  localparam logic [CNT_W-1:0]   ONE      = CNT_W'(1);
  localparam logic [NPHASES-1:0] PH0      = NPHASES'(1);

  phase_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NPHASES-1:0] pen_q, pen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic               oneshot_q, oneshot_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_expire;
  logic [CNT_W-1:0]   tmr_cnt;
  logic [CNT_W-1:0]   tmr_next;
  logic [CNT_W-1:0]   dwell_in_eff;
  logic               advance;
  logic               start_round;

  assign dwell_in_eff = (dwell == '0) ? ONE : dwell;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pen_d       = pen_q;
    busy_d      = busy_q;
    dwell_d     = dwell_q;
    gap_d       = gap_q;
    oneshot_d   = oneshot_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    advance     = 1'b0;
    start_round = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) start_round = 1'b1;
      end
      ACTIVE: begin
        if (tmr_expire) begin
          if (gap_q != '0) begin
            state_d  = GAP;
            pen_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = gap_q - ONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      GAP: begin
        if (tmr_expire) advance = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving the last phase is the round boundary: stop, or re-latch settings and wrap.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        if (oneshot_q || !enable) begin
          state_d = IDLE;
          pen_d   = '0;
          busy_d  = 1'b0;
        end else begin
          start_round = 1'b1;
        end
      end else begin
        state_d  = ACTIVE;
        idx_d    = idx_q + IDX_W'(1);
        pen_d    = PH0 << idx_d;
        tmr_load = 1'b1;
        tmr_val  = dwell_q - ONE;
      end
    end

    if (start_round) begin
      state_d   = ACTIVE;
      idx_d     = '0;
      pen_d     = PH0;
      busy_d    = 1'b1;
      dwell_d   = dwell_in_eff;
      gap_d     = gap;
      oneshot_d = oneshot;
      tmr_load  = 1'b1;
      tmr_val   = dwell_in_eff - ONE;
    end

    // Registered pulse lands on the cycle the last phase's timer reads zero.
    tmr_next = tmr_load ? tmr_val : (tmr_cnt - ONE);
    done_d   = (state_d == ACTIVE) && (idx_d == LAST_IDX) && (tmr_next == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pen_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dwell_q   <= ONE;
      gap_q     <= '0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pen_q     <= pen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dwell_q   <= dwell_d;
      gap_q     <= gap_d;
      oneshot_q <= oneshot_d;
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire),
    .count    (tmr_cnt)
  );

  assign phase_en   = pen_q;
  assign phase_idx  = idx_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench: expected per-cycle {phase_en, phase_idx, busy, cycle_done} queued from the
// behavioural timing rules, popped and compared every cycle on the falling edge.
module tb_phase_sequencer;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       oneshot;
  logic [7:0] dwell;
  logic [7:0] gap;

  logic [3:0] pen4;
  logic [1:0] idx4;
  logic       busy4;
  logic       done4;
  logic [2:0] pen3;
  logic [1:0] idx3;
  logic       busy3;
  logic       done3;

  logic [7:0] obs4;
  logic [7:0] obs3;

  int vectors;
  int miscompares;

  logic [7:0] exp_q[$];

  phase_sequencer #(.NPHASES(4), .CNT_W(8)) u_dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .oneshot    (oneshot),
    .dwell      (dwell),
    .gap        (gap),
    .phase_en   (pen4),
    .phase_idx  (idx4),
    .busy       (busy4),
    .cycle_done (done4)
  );

  phase_sequencer #(.NPHASES(3), .CNT_W(8)) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .oneshot    (oneshot),
    .dwell      (dwell),
    .gap        (gap),
    .phase_en   (pen3),
    .phase_idx  (idx3),
    .busy       (busy3),
    .cycle_done (done3)
  );

  assign obs4 = {pen4, idx4, busy4, done4};
  assign obs3 = {1'b0, pen3, idx3, busy3, done3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mk(input logic [3:0] pen, input logic [1:0] idx,
                                    input logic bsy, input logic dn);
    return {pen, idx, bsy, dn};
  endfunction

  task automatic push_round(input int n, input int d, input int g);
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < d; k++)
        exp_q.push_back(mk(4'(1 << p), 2'(p), 1'b1, (p == n - 1) && (k == d - 1)));
      for (int k = 0; k < g; k++)
        exp_q.push_back(mk(4'b0, 2'(p), 1'b1, 1'b0));
    end
  endtask

  task automatic push_idle(input int n);
    exp_q.push_back(mk(4'b0, 2'(n - 1), 1'b0, 1'b0));
  endtask

  task automatic idle_pad();
    enable = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      vectors++;
      if (!$onehot0(pen4) || !$onehot0(pen3)) begin
        miscompares++;
        $display("FAIL onehot t=%0t got pen4=%b pen3=%b want at most one bit", $time, pen4, pen3);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    oneshot = 1'b0;
    dwell   = 8'd1;
    gap     = 8'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs4 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset4 got %h want 00", obs4);
    end
    vectors++;
    if (obs3 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset3 got %h want 00", obs3);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs4 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release got %h want 00", obs4);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    for (int c = 0; c < 7; c++)
      exp_q.push_back(mk(4'(1 << (c / 3)), 2'(c / 3), 1'b1, 1'b0));
    dwell = 8'd3; gap = 8'd0; oneshot = 1'b0; enable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs4 !== e) begin
        miscompares++;
        $display("FAIL reset_mid_run c=%0d got %h want %h", c, obs4, e);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (obs4 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async4 got %h want 00", obs4);
    end
    vectors++;
    if (obs3 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async3 got %h want 00", obs3);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_pad();
  endtask

  task automatic test_legacy();
    logic [7:0] e;
    repeat (3) push_round(4, 1, 0);
    push_idle(4);
    dwell = 8'd1; gap = 8'd0; oneshot = 1'b0; enable = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs4 !== e) begin
        miscompares++;
        $display("FAIL legacy c=%0d got %h want %h", c, obs4, e);
      end
      if (c == 11) enable = 1'b0;
    end
    idle_pad();
  endtask

  task automatic test_dwell_gap();
    logic [7:0] e;
    repeat (2) push_round(3, 2, 1);
    push_idle(3);
    dwell = 8'd2; gap = 8'd1; oneshot = 1'b0; enable = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs3 !== e) begin
        miscompares++;
        $display("FAIL dwell_gap c=%0d got %h want %h", c, obs3, e);
      end
      if (c == 10) enable = 1'b0;
    end
    idle_pad();
  endtask

  task automatic test_oneshot();
    logic [7:0] e;
    push_round(4, 1, 0);
    push_idle(4);
    dwell = 8'd1; gap = 8'd0; oneshot = 1'b1; enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs4 !== e) begin
        miscompares++;
        $display("FAIL oneshot c=%0d got %h want %h", c, obs4, e);
      end
    end
    oneshot = 1'b0;
    idle_pad();
  endtask

  task automatic test_graceful_stop();
    logic [7:0] e;
    push_round(4, 4, 0);
    push_idle(4);
    push_round(4, 1, 0);
    push_idle(4);
    dwell = 8'd4; gap = 8'd0; oneshot = 1'b0; enable = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs4 !== e) begin
        miscompares++;
        $display("FAIL graceful c=%0d got %h want %h", c, obs4, e);
      end
      if (c == 5) begin
        enable = 1'b0;
        dwell  = 8'd1;
      end
      if (c == 16) enable = 1'b1;
      if (c == 17) enable = 1'b0;
    end
    idle_pad();
  endtask

  task automatic test_dwell_limits();
    logic [7:0] e;
    push_round(4, 1, 0);
    push_idle(4);
    dwell = 8'd0; gap = 8'd0; oneshot = 1'b1; enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs4 !== e) begin
        miscompares++;
        $display("FAIL dwell_zero c=%0d got %h want %h", c, obs4, e);
      end
      if (c == 0) enable = 1'b0;
    end
    idle_pad();
    push_round(4, 255, 0);
    push_idle(4);
    dwell = 8'd255; gap = 8'd0; oneshot = 1'b1; enable = 1'b1;
    for (int c = 0; c < 1021; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs4 !== e) begin
        miscompares++;
        $display("FAIL dwell_max c=%0d got %h want %h", c, obs4, e);
      end
      if (c == 0) enable = 1'b0;
    end
    oneshot = 1'b0;
    idle_pad();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_legacy();
    test_dwell_gap();
    test_oneshot();
    test_graceful_stop();
    test_dwell_limits();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
